// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_ILLEGAL
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    localparam int MAX_LATENCY = 4;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    // Pick the addressed lane(s) out of a little-endian word and extend to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input mem_size_e   sz,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: load_extend = {{24{b[7] & ~uns}}, b};
            SZ_HALF: load_extend = {{16{h[15] & ~uns}}, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-wide storage array with per-byte write enables and a read-first synchronous read port.
module dmem_bram #(
    parameter int DEPTH_WORDS = 128,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          re_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
                mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
        // Read only on demand so the last load word stays put while the response waits.
        if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/dmem_bytes.sv
// MEM-stage data memory: byte/half/word loads and stores behind a one-outstanding
// valid/ready handshake with configurable read latency and an error response.
module dmem_bytes
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ld_q;
    logic             err_q;
    logic [1:0]       lane_q;
    mem_size_e        size_q;
    logic             uns_q;

    mem_size_e        size_d;
    logic             accept;
    logic             shape_err;
    logic             range_err;
    logic             acc_err;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [3:0]       bram_be;
    logic             bram_re;
    logic [31:0]      bram_rdata;

    assign size_d    = mem_size_e'(req_size);
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign range_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_err   = shape_err | range_err;

    // Replicate the store data across the word so every enabled lane sees its bytes.
    always_comb begin
        be_d      = 4'b0000;
        wdata_d   = req_wdata;
        shape_err = 1'b0;
        case (size_d)
            SZ_BYTE: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_d      = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d   = {2{req_wdata[15:0]}};
                shape_err = req_addr[0];
            end
            SZ_WORD: begin
                be_d      = 4'b1111;
                shape_err = |req_addr[1:0];
            end
            default: shape_err = 1'b1;
        endcase
    end

    assign bram_be = (accept && req_we && !acc_err) ? be_d : 4'b0000;
    assign bram_re = accept && !req_we && !acc_err;

    dmem_bram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bram (
        .clk     (clk),
        .addr_i  (req_addr[AW+1:2]),
        .re_i    (bram_re),
        .be_i    (bram_be),
        .wdata_i (wdata_d),
        .rdata_o (bram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        err_q <= acc_err;
                        ld_q  <= !req_we && !acc_err;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        ld_q    <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lane_q <= req_addr[1:0];
            size_q <= size_d;
            uns_q  <= req_unsigned;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign resp_rdata = ld_q ? load_extend(bram_rdata, lane_q, size_q, uns_q) : 32'h0;

endmodule

// File: doc/dmem_bytes.md
# dmem_bytes

Parametrised, byte-addressable data memory for the MIPS core's MEM stage; successor to the plain word-only data RAM. It adds byte/halfword/word loads and stores with sign/zero extension, byte-lane write enables, a configurable read latency behind a valid/ready request/response handshake, and an error response for misaligned or out-of-range accesses. It holds one outstanding request at a time.

## Interface
- DEPTH_WORDS, 128: number of 32-bit words; power of two, ≥4.
- LATENCY, 1: cycles from request acceptance to response valid; legal range 1..4.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend (1) or sign-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access was misaligned, out of range, or illegal size

## Operation
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE) && !reset.
- Accept when req_valid && req_ready at a rising edge. Latch the response contents at that edge.
- Error check at accept:
  - half with addr[0]≠0 is an error.
  - word with addr[1:0]≠0 is an error.
  - req_size==11 is an error.
  - addr[31:2] ≥ DEPTH_WORDS is an error.
  - On error: no write, resp_err=1, resp_rdata=0.
- Byte order is little-endian: lane k = word bits [8k+7:8k], selected by addr[1:0].
- Store: written into the array at the accept edge through byte enables.
  - byte: one lane, data req_wdata[7:0].
  - half: lanes {2a+1,2a} with a = addr[1], data req_wdata[15:0].
  - word: all lanes.
  - Unwritten lanes are unchanged. resp_rdata=0, resp_err=0.
- Load: read the addressed word at the accept edge (old contents), extract the lane(s), extend to 32 bits per req_unsigned, and register the result.
- Transitions:
  - IDLE→RESP on accept if LATENCY==1, else IDLE→WAIT with the counter loaded to LATENCY-1.
  - WAIT decrements the counter and goes to RESP when it reaches 1.
  - RESP→IDLE when resp_ready is high.
- Inputs are ignored while not in IDLE.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, counter 0. req_ready is 0 during the reset cycle and 1 the cycle after.
- RAM contents are not reset.
- resp_valid rises exactly LATENCY cycles after the accept edge.
- resp_valid, resp_rdata and resp_err stay stable until the resp_ready handshake.
- The earliest next accept is the cycle after the response handshake. Peak throughput is one access per LATENCY+1 cycles when resp_ready is held high.
- A load following a store to the same word (separate requests) returns the new data.
- Reset mid-operation (WAIT or RESP) drops the pending response. A store already committed at its accept edge remains in memory.
- resp_ready held low: stay in RESP indefinitely, outputs held.

## Structure
- Package dmem_pkg holds:
  - typedef enum logic[1:0] mem_size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL};
  - typedef enum dmem_state_e {IDLE, WAIT, RESP};
  - localparam for the maximum LATENCY.
- Sub-module dmem_bram: DEPTH_WORDS×32 array with a 4-bit byte write enable, word address input and read-first synchronous read port.
- The top level holds the FSM, latency counter, alignment/range check, store lane steering and load extraction/extension.

## Test plan
- Word store then load, LATENCY=1:
  - Store 0xDEADBEEF to 0x10, then load word from 0x10.
  - resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 1 cycle after accept.
- Sub-word stores and loads:
  - Store 0xAA to byte 0x21 and 0x8001 to half 0x22 over a word pre-loaded with 0x00000000.
  - Load word from 0x20 returns 0x8001AA00.
  - lb from 0x21 returns 0xFFFFFFAA.
  - lbu from 0x21 returns 0x000000AA.
  - lh from 0x22 returns 0xFFFF8001.
- Errors:
  - Half load at 0x13 gives resp_err=1, rdata=0.
  - Word store at 0x4·DEPTH_WORDS gives resp_err=1; a subsequent load of word 0 is unchanged.
  - req_size=11 gives resp_err=1.
- LATENCY=3 with resp_ready low for 5 cycles:
  - resp_valid rises 3 cycles after accept and is held stable.
  - req_ready stays 0 throughout and returns 1 the cycle after the handshake.
- Reset in WAIT:
  - Assert reset 1 cycle after accepting a store of 0x12345678 (LATENCY=3).
  - No resp_valid appears; a later load returns 0x12345678.
- Back-to-back traffic:
  - Hold req_valid and resp_ready high for 20 random accesses, checked against a byte-array model.
  - Each access is accepted every LATENCY+1 cycles.
